// File: rtl/mem_arb_pkg.sv
// Shared widths and types for the mem arbiter: address/data types, port identity
// and the round-robin rule.
package mem_arb_pkg;

  localparam int HBIT_ADDR = 9;
  localparam int HBIT_DATA = 23;

  typedef logic [HBIT_ADDR:0] addr_t;
  typedef logic [HBIT_DATA:0] data_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // On a conflict the port that did not win last time gets the grant.
  function automatic port_e rr_winner(input port_e last);
    return (last == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, load/store port and mem-side signals around mem_arb.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic  iw_i_valid;
  addr_t iw_i_addr;
  logic  ow_i_ready;
  logic  or_i_rvalid;
  data_t or_i_rdata;

  logic  iw_d_valid;
  logic  iw_d_we;
  addr_t iw_d_addr;
  data_t iw_d_wdata;
  logic  ow_d_ready;
  logic  or_d_rvalid;
  data_t or_d_rdata;

  logic  ow_mem_we;
  addr_t ow_mem_addr;
  data_t ow_mem_wdata;
  data_t iw_mem_rdata;

  modport slave (
    input  iw_i_valid, iw_i_addr,
    output ow_i_ready, or_i_rvalid, or_i_rdata,
    input  iw_d_valid, iw_d_we, iw_d_addr, iw_d_wdata,
    output ow_d_ready, or_d_rvalid, or_d_rdata,
    output ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  iw_mem_rdata
  );

  modport master (
    output iw_i_valid, iw_i_addr,
    input  ow_i_ready, or_i_rvalid, or_i_rdata,
    output iw_d_valid, iw_d_we, iw_d_addr, iw_d_wdata,
    input  ow_d_ready, or_d_rvalid, or_d_rdata,
    input  ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output iw_mem_rdata
  );

endinterface

// File: rtl/mem_arb_rr2.sv
// Two-requester arbiter (insn vs data) with optional fixed data priority.
// state  | meaning
// PORT_I | insn port granted most recently (reset value)
// PORT_D | data port granted most recently
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter int P_DATA_PRIO = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);

  port_e last_q, last_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_q <= PORT_I;
    else          last_q <= last_d;
  end

  always_comb begin
    gnt_i_o = 1'b0;
    gnt_d_o = 1'b0;
    last_d  = last_q;
    if (req_i_i && req_d_i) begin
      if ((P_DATA_PRIO != 0) || (rr_winner(last_q) == PORT_D)) gnt_d_o = 1'b1;
      else                                                     gnt_i_o = 1'b1;
    end else if (req_d_i) begin
      gnt_d_o = 1'b1;
    end else if (req_i_i) begin
      gnt_i_o = 1'b1;
    end
    if (gnt_d_o)      last_d = PORT_D;
    else if (gnt_i_o) last_d = PORT_I;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter and read sequencer in front of the single-port mem: one grant per cycle,
// one-cycle read latency, read data routed back to the issuing port.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int P_DATA_PRIO = 0
) (
  input logic       iw_clk,
  input logic       iw_rst_n,
  mem_arb_if.slave  bus
);

  logic  gnt_i, gnt_d;
  logic  pend_i_q, pend_i_d;
  logic  pend_d_q, pend_d_d;
  data_t rdata_i_q, rdata_i_d;
  data_t rdata_d_q, rdata_d_d;

  arb_rr2 #(.P_DATA_PRIO(P_DATA_PRIO)) u_arb (
    .clk_i   (iw_clk),
    .rst_n_i (iw_rst_n),
    .req_i_i (bus.iw_i_valid),
    .req_d_i (bus.iw_d_valid),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  // Grants are masked by reset so nothing, writes included, issues while held in reset.
  assign bus.ow_i_ready   = gnt_i && iw_rst_n;
  assign bus.ow_d_ready   = gnt_d && iw_rst_n;
  assign bus.ow_mem_we    = bus.ow_d_ready && bus.iw_d_we;
  assign bus.ow_mem_addr  = gnt_d ? bus.iw_d_addr : bus.iw_i_addr;
  assign bus.ow_mem_wdata = gnt_d ? bus.iw_d_wdata : '0;

  always_comb begin
    pend_i_d  = bus.ow_i_ready;
    pend_d_d  = bus.ow_d_ready && !bus.iw_d_we;
    rdata_i_d = pend_i_q ? bus.iw_mem_rdata : rdata_i_q;
    rdata_d_d = pend_d_q ? bus.iw_mem_rdata : rdata_d_q;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      pend_i_q  <= pend_i_d;
      pend_d_q  <= pend_d_d;
      rdata_i_q <= rdata_i_d;
      rdata_d_q <= rdata_d_d;
    end
  end

  // Returned data is visible in the response cycle, then held by the register.
  assign bus.or_i_rvalid = pend_i_q;
  assign bus.or_i_rdata  = rdata_i_d;
  assign bus.or_d_rvalid = pend_d_q;
  assign bus.or_d_rdata  = rdata_d_d;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized run against a
// transaction-level reference model. Two instances cover round-robin and data priority.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus0 ();
  mem_arb_if bus1 ();

  mem_arb #(.P_DATA_PRIO(0)) dut0 (.iw_clk(clk), .iw_rst_n(rst_n), .bus(bus0));
  mem_arb #(.P_DATA_PRIO(1)) dut1 (.iw_clk(clk), .iw_rst_n(rst_n), .bus(bus1));

  data_t mem0    [1024];
  data_t mem1    [1024];
  data_t ref_mem [1024];

  logic  pl_en   = 1'b0;
  addr_t pl_addr = '0;
  data_t pl_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: last winner (1 = data), outstanding reads, held data
  bit    m_last, m_pend_i, m_pend_d;
  data_t m_ival, m_dval, m_ihold, m_dhold;

  // behavioural single-port mem, one-cycle read latency
  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end else begin
      if (bus0.ow_mem_we) mem0[bus0.ow_mem_addr] <= bus0.ow_mem_wdata;
      if (bus1.ow_mem_we) mem1[bus1.ow_mem_addr] <= bus1.ow_mem_wdata;
    end
    bus0.iw_mem_rdata <= mem0[bus0.ow_mem_addr];
    bus1.iw_mem_rdata <= mem1[bus1.ow_mem_addr];
  end

  function automatic data_t pattern(input int a);
    if (a == 'h010) return 24'hA0A0A0;
    if (a == 'h011) return 24'hB1B1B1;
    return data_t'((a * 24'h01357) ^ 24'h5A5A5A);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.iw_i_valid = 1'b0; bus0.iw_i_addr = '0;
    bus0.iw_d_valid = 1'b0; bus0.iw_d_we = 1'b0; bus0.iw_d_addr = '0; bus0.iw_d_wdata = '0;
    bus1.iw_i_valid = 1'b0; bus1.iw_i_addr = '0;
    bus1.iw_d_valid = 1'b0; bus1.iw_d_we = 1'b0; bus1.iw_d_addr = '0; bus1.iw_d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_last = 1'b0; m_pend_i = 1'b0; m_pend_d = 1'b0;
    m_ival = '0; m_dval = '0; m_ihold = '0; m_dhold = '0;
  endtask

  task automatic preload();
    for (int a = 0; a < 1024; a++) begin
      pl_en   = 1'b1;
      pl_addr = addr_t'(a);
      pl_data = pattern(a);
      ref_mem[a] = pattern(a);
      step();
    end
    pl_en = 1'b0;
    step();
  endtask

  // reset held while both ports request, including a write
  task automatic test_reset();
    rst_n = 1'b0;
    bus0.iw_i_valid = 1'b1; bus0.iw_i_addr = 10'h010;
    bus0.iw_d_valid = 1'b1; bus0.iw_d_we = 1'b1; bus0.iw_d_addr = 10'h020; bus0.iw_d_wdata = 24'hDEAD11;
    bus1.iw_d_valid = 1'b1; bus1.iw_d_we = 1'b1; bus1.iw_d_addr = 10'h020; bus1.iw_d_wdata = 24'hDEAD22;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus0.ow_mem_we !== 1'b0 || bus1.ow_mem_we !== 1'b0)
        $display("FAIL reset_we: got %b/%b want 0/0", bus0.ow_mem_we, bus1.ow_mem_we);
      else n_pass++;
      n_chk++;
      if (bus0.ow_i_ready !== 1'b0 || bus0.ow_d_ready !== 1'b0)
        $display("FAIL reset_ready: got i=%b d=%b want 0", bus0.ow_i_ready, bus0.ow_d_ready);
      else n_pass++;
      n_chk++;
      if (bus0.or_i_rvalid !== 1'b0 || bus0.or_d_rvalid !== 1'b0)
        $display("FAIL reset_rvalid: got i=%b d=%b want 0", bus0.or_i_rvalid, bus0.or_d_rvalid);
      else n_pass++;
      n_chk++;
      if (bus0.or_i_rdata !== '0 || bus0.or_d_rdata !== '0)
        $display("FAIL reset_rdata: got i=%h d=%h want 0", bus0.or_i_rdata, bus0.or_d_rdata);
      else n_pass++;
      step();
    end
    clear_inputs();
    rst_n = 1'b1;
    step();
    n_chk++;
    if (mem0[10'h020] !== ref_mem[10'h020] || mem1[10'h020] !== ref_mem[10'h020])
      $display("FAIL reset_mem_unchanged: got %h/%h want %h", mem0[10'h020], mem1[10'h020], ref_mem[10'h020]);
    else n_pass++;
  endtask

  // two consecutive insn reads, then idle: pulses and held data
  task automatic test_insn_reads();
    bit    exp_rv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    data_t exp_rd [6] = '{24'h0, 24'hA0A0A0, 24'hB1B1B1, 24'hB1B1B1, 24'hB1B1B1, 24'hB1B1B1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus0.iw_i_valid = (c < 2);
      bus0.iw_i_addr  = (c == 0) ? 10'h010 : 10'h011;
      @(negedge clk);
      if (c < 2) begin
        n_chk++;
        if (bus0.ow_i_ready !== 1'b1 || bus0.ow_d_ready !== 1'b0 || bus0.ow_mem_addr !== bus0.iw_i_addr)
          $display("FAIL insn_grant c%0d: got i=%b d=%b addr=%h want 1 0 %h", c,
                   bus0.ow_i_ready, bus0.ow_d_ready, bus0.ow_mem_addr, bus0.iw_i_addr);
        else n_pass++;
      end
      n_chk++;
      if (bus0.or_i_rvalid !== exp_rv[c] || bus0.or_i_rdata !== exp_rd[c])
        $display("FAIL insn_rsp c%0d: got rv=%b rd=%h want rv=%b rd=%h", c,
                 bus0.or_i_rvalid, bus0.or_i_rdata, exp_rv[c], exp_rd[c]);
      else n_pass++;
      n_chk++;
      if (bus0.or_d_rvalid !== 1'b0)
        $display("FAIL insn_no_drvalid c%0d: got %b want 0", c, bus0.or_d_rvalid);
      else n_pass++;
      step();
    end
  endtask

  // write then read the same address on consecutive cycles
  task automatic test_raw();
    int we_cnt = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus0.iw_d_valid = (c < 2);
      bus0.iw_d_we    = (c == 0);
      bus0.iw_d_addr  = 10'h020;
      bus0.iw_d_wdata = 24'h123456;
      @(negedge clk);
      if (bus0.ow_mem_we === 1'b1) we_cnt++;
      if (c == 0) begin
        n_chk++;
        if (bus0.ow_d_ready !== 1'b1 || bus0.ow_mem_addr !== 10'h020 || bus0.ow_mem_wdata !== 24'h123456)
          $display("FAIL raw_write: got rdy=%b addr=%h wd=%h want 1 020 123456",
                   bus0.ow_d_ready, bus0.ow_mem_addr, bus0.ow_mem_wdata);
        else n_pass++;
      end
      n_chk++;
      if (bus0.or_d_rvalid !== (c == 2))
        $display("FAIL raw_rvalid c%0d: got %b want %b", c, bus0.or_d_rvalid, (c == 2));
      else n_pass++;
      if (c == 2) begin
        n_chk++;
        if (bus0.or_d_rdata !== 24'h123456)
          $display("FAIL raw_rdata: got %h want 123456", bus0.or_d_rdata);
        else n_pass++;
      end
      step();
    end
    ref_mem[10'h020] = 24'h123456;
    n_chk++;
    if (we_cnt != 1) $display("FAIL raw_we_pulses: got %0d want 1", we_cnt);
    else n_pass++;
  endtask

  // both ports valid for 6 cycles under round-robin
  task automatic test_conflict_rr();
    data_t qi[$];
    data_t qd[$];
    int ni = 0, nd = 0, ki = 0, kd = 0;
    bit exp_d;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus0.iw_i_valid = (c < 6);
      bus0.iw_d_valid = (c < 6);
      bus0.iw_d_we    = 1'b0;
      bus0.iw_i_addr  = addr_t'(10'h030 + ki);
      bus0.iw_d_addr  = addr_t'(10'h040 + kd);
      exp_d = (c % 2 == 0);
      @(negedge clk);
      if (c < 6) begin
        n_chk++;
        if (bus0.ow_d_ready !== exp_d || bus0.ow_i_ready !== !exp_d)
          $display("FAIL rr_grant c%0d: got d=%b i=%b want d=%b i=%b", c,
                   bus0.ow_d_ready, bus0.ow_i_ready, exp_d, !exp_d);
        else n_pass++;
      end
      if (bus0.or_i_rvalid === 1'b1) begin
        ni++;
        n_chk++;
        if (qi.size() == 0 || bus0.or_i_rdata !== qi[0])
          $display("FAIL rr_i_rdata c%0d: got %h want %h", c, bus0.or_i_rdata, (qi.size() != 0) ? qi[0] : 24'h0);
        else n_pass++;
        if (qi.size() != 0) void'(qi.pop_front());
      end
      if (bus0.or_d_rvalid === 1'b1) begin
        nd++;
        n_chk++;
        if (qd.size() == 0 || bus0.or_d_rdata !== qd[0])
          $display("FAIL rr_d_rdata c%0d: got %h want %h", c, bus0.or_d_rdata, (qd.size() != 0) ? qd[0] : 24'h0);
        else n_pass++;
        if (qd.size() != 0) void'(qd.pop_front());
      end
      if (c < 6) begin
        if (exp_d) begin qd.push_back(ref_mem[10'h040 + kd]); kd++; end
        else       begin qi.push_back(ref_mem[10'h030 + ki]); ki++; end
      end
      step();
    end
    n_chk++;
    if (ni != 3 || nd != 3) $display("FAIL rr_pulse_count: got i=%0d d=%0d want 3 3", ni, nd);
    else n_pass++;
  endtask

  // fixed data priority: insn port starves while data is valid
  task automatic test_data_prio();
    int nd = 0, ni = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus1.iw_i_valid = (c < 6);
      bus1.iw_d_valid = (c < 6);
      bus1.iw_d_we    = 1'b0;
      bus1.iw_i_addr  = 10'h070;
      bus1.iw_d_addr  = addr_t'(10'h050 + c);
      @(negedge clk);
      if (c < 6) begin
        n_chk++;
        if (bus1.ow_d_ready !== 1'b1 || bus1.ow_i_ready !== 1'b0)
          $display("FAIL prio_grant c%0d: got d=%b i=%b want 1 0", c, bus1.ow_d_ready, bus1.ow_i_ready);
        else n_pass++;
      end
      if (bus1.or_i_rvalid === 1'b1) ni++;
      if (bus1.or_d_rvalid === 1'b1) begin
        nd++;
        n_chk++;
        if (bus1.or_d_rdata !== ref_mem[10'h050 + c - 1])
          $display("FAIL prio_rdata c%0d: got %h want %h", c, bus1.or_d_rdata, ref_mem[10'h050 + c - 1]);
        else n_pass++;
      end
      step();
    end
    n_chk++;
    if (nd != 6 || ni != 0) $display("FAIL prio_pulse_count: got d=%0d i=%0d want 6 0", nd, ni);
    else n_pass++;
  endtask

  // reset lands while a data read response is in flight
  task automatic test_reset_mid_read();
    do_reset();
    bus0.iw_d_valid = 1'b1; bus0.iw_d_we = 1'b0; bus0.iw_d_addr = 10'h011;
    @(negedge clk);
    n_chk++;
    if (bus0.ow_d_ready !== 1'b1) $display("FAIL midrst_grant: got %b want 1", bus0.ow_d_ready);
    else n_pass++;
    step();
    clear_inputs();
    n_chk++;
    if (bus0.or_d_rvalid !== 1'b1 || bus0.or_d_rdata !== 24'hB1B1B1)
      $display("FAIL midrst_pre: got rv=%b rd=%h want 1 b1b1b1", bus0.or_d_rvalid, bus0.or_d_rdata);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus0.or_d_rvalid !== 1'b0 || bus0.or_d_rdata !== '0)
      $display("FAIL midrst_async: got rv=%b rd=%h want 0 0", bus0.or_d_rvalid, bus0.or_d_rdata);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus0.or_d_rvalid !== 1'b0 || bus0.or_i_rvalid !== 1'b0)
        $display("FAIL midrst_after c%0d: got d=%b i=%b want 0 0", c, bus0.or_d_rvalid, bus0.or_i_rvalid);
      else n_pass++;
      step();
    end
  endtask

  // random traffic with requesters holding until granted
  task automatic test_random();
    bit    i_act = 1'b0, d_act = 1'b0, d_we = 1'b0;
    addr_t i_a = '0, d_a = '0;
    data_t d_wd = '0;
    bit    g_i, g_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!i_act && $urandom_range(0, 2) != 0) begin
        i_act = 1'b1;
        i_a   = addr_t'($urandom_range(0, 15));
      end
      if (!d_act && $urandom_range(0, 2) != 0) begin
        d_act = 1'b1;
        d_we  = 1'($urandom_range(0, 1));
        d_a   = addr_t'($urandom_range(0, 15));
        d_wd  = data_t'($urandom);
      end
      bus0.iw_i_valid = i_act; bus0.iw_i_addr = i_a;
      bus0.iw_d_valid = d_act; bus0.iw_d_we = d_we; bus0.iw_d_addr = d_a; bus0.iw_d_wdata = d_wd;
      g_i = 1'b0;
      g_d = 1'b0;
      if (i_act && d_act) begin
        if (m_last) g_i = 1'b1;
        else        g_d = 1'b1;
      end else if (d_act) g_d = 1'b1;
      else if (i_act)     g_i = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus0.ow_i_ready !== g_i || bus0.ow_d_ready !== g_d)
        $display("FAIL rand_grant c%0d: got i=%b d=%b want i=%b d=%b", c, bus0.ow_i_ready, bus0.ow_d_ready, g_i, g_d);
      else n_pass++;
      n_chk++;
      if (bus0.ow_mem_we !== (g_d && d_we))
        $display("FAIL rand_we c%0d: got %b want %b", c, bus0.ow_mem_we, (g_d && d_we));
      else n_pass++;
      n_chk++;
      if (bus0.or_i_rvalid !== m_pend_i || bus0.or_i_rdata !== (m_pend_i ? m_ival : m_ihold))
        $display("FAIL rand_i_rsp c%0d: got rv=%b rd=%h want rv=%b rd=%h", c,
                 bus0.or_i_rvalid, bus0.or_i_rdata, m_pend_i, (m_pend_i ? m_ival : m_ihold));
      else n_pass++;
      n_chk++;
      if (bus0.or_d_rvalid !== m_pend_d || bus0.or_d_rdata !== (m_pend_d ? m_dval : m_dhold))
        $display("FAIL rand_d_rsp c%0d: got rv=%b rd=%h want rv=%b rd=%h", c,
                 bus0.or_d_rvalid, bus0.or_d_rdata, m_pend_d, (m_pend_d ? m_dval : m_dhold));
      else n_pass++;
      if (m_pend_i) m_ihold = m_ival;
      if (m_pend_d) m_dhold = m_dval;
      m_pend_i = g_i;
      m_pend_d = g_d && !d_we;
      if (g_i) m_ival = ref_mem[i_a];
      if (g_d && !d_we) m_dval = ref_mem[d_a];
      if (g_d && d_we) ref_mem[d_a] = d_wd;
      if (g_i || g_d) m_last = g_d;
      if (g_i) i_act = 1'b0;
      if (g_d) d_act = 1'b0;
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    preload();
    test_reset();
    test_insn_reads();
    test_raw();
    test_conflict_rr();
    test_data_prio();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter and request sequencer in front of the single-port 24-bit `mem` block. It accepts read requests from the instruction-fetch port and read/write requests from the load/store data port. Each cycle it grants at most one request to `mem`, tracks the one-cycle read latency, and returns read data to the requester that issued it. It sits between the core's fetch/LSU stages and `mem`, and is the only driver of `mem`'s write enable, address and write data.

## Interface
Parameters:
- `P_DATA_PRIO`, default 0. 0 = round-robin between ports on conflict; 1 = data port always wins.

Ports:
- `iw_clk`  in  1  clock.
- `iw_rst_n`  in  1  asynchronous active-low reset.
- `iw_i_valid`  in  1  instruction read request valid.
- `iw_i_addr`  in  `HBIT_ADDR`+1  instruction read address.
- `ow_i_ready`  out  1  instruction request granted this cycle.
- `or_i_rvalid`  out  1  instruction read data valid; one-cycle pulse.
- `or_i_rdata`  out  `HBIT_DATA`+1  instruction read data; held until the next instruction read returns.
- `iw_d_valid`  in  1  data request valid.
- `iw_d_we`  in  1  1 = write, 0 = read.
- `iw_d_addr`  in  `HBIT_ADDR`+1  data address.
- `iw_d_wdata`  in  `HBIT_DATA`+1  data write value.
- `ow_d_ready`  out  1  data request granted this cycle.
- `or_d_rvalid`  out  1  data read data valid; one-cycle pulse. Never asserted for writes.
- `or_d_rdata`  out  `HBIT_DATA`+1  data read data; held until the next data read returns.
- `ow_mem_we`  out  1  to `mem` `iw_we`.
- `ow_mem_addr`  out  `HBIT_ADDR`+1  to `mem` `iw_addr`.
- `ow_mem_wdata`  out  `HBIT_DATA`+1  to `mem` `iw_wdata`.
- `iw_mem_rdata`  in  `HBIT_DATA`+1  from `mem` `or_rdata`.

## Operation
- A request transfers when `valid && ready` in the same cycle. Requesters hold `valid`, `addr`, `we` and `wdata` stable until granted.
- Grant is combinational from the valids and registered arbiter state. At most one of `ow_i_ready` / `ow_d_ready` is high in any cycle.
- Only one port valid: that port is granted.
- Both ports valid:
  - `P_DATA_PRIO=1`: data port granted.
  - `P_DATA_PRIO=0`: the port not granted most recently wins. `r_last` holds 0 = insn, 1 = data, and updates on every grant.
- Mem drive:
  - `ow_mem_addr` and `ow_mem_wdata` mux from the granted port.
  - With no grant, `ow_mem_addr` holds the insn address and `ow_mem_wdata` = 0.
  - `ow_mem_we = ow_d_ready && iw_d_we && iw_rst_n`. A write is never issued during reset.
- Read tracking:
  - On a granted read, set `r_pend_i` or `r_pend_d` (at most one set per cycle).
  - Next cycle, the pending flag pulses the matching `rvalid` and loads `iw_mem_rdata` into the matching `rdata` register. The flag then clears unless a new read for that port is granted.
- Write: completes at grant. No response.
- No response backpressure. Consumers must accept an `rvalid` pulse when it occurs.

## Timing
- Read latency: grant in cycle N → `rvalid` and `rdata` in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads on the same port give consecutive `rvalid` pulses.
- Read-after-write to the same address in consecutive cycles returns the new value. Write and read cannot share a cycle (single grant).
- Reset (async assert, sync-safe deassert): all of the following go to 0 immediately:
  - `r_pend_i`, `r_pend_d`, `r_last`
  - `or_i_rvalid`, `or_d_rvalid`
  - `or_i_rdata`, `or_d_rdata`
  - `ow_i_ready`, `ow_d_ready`, `ow_mem_we`
- Reset mid-read: the in-flight response is dropped and no `rvalid` follows after deassertion.
- First conflict after reset (`P_DATA_PRIO=0`): data port wins, because `r_last`=0 means insn was "last".

## Structure
- Width macros `HBIT_ADDR` and `HBIT_DATA` come from `src2/sizes.vh`. No new constants are needed there.
- One sub-module: `arb_rr2`, a two-requester round-robin arbiter holding `r_last` and honouring `P_DATA_PRIO`. The rest is grant muxing and response registers in `mem_arb`.
- The top-level integration instantiates `mem_arb` with `mem` and wires the `ow_mem_*` / `iw_mem_rdata` pair directly.

## Test plan
- Insn-only reads of addr 0x010 then 0x011 on consecutive cycles, mem preloaded with 0xA0A0A0 / 0xB1B1B1 → `or_i_rvalid` high in cycles N+1 and N+2 with those values; `or_d_rvalid` stays 0.
- Data write of 0x123456 to 0x020, then data read of 0x020 the next cycle → `ow_mem_we` pulses exactly once; read returns 0x123456 one cycle after its grant.
- Both ports valid continuously for 6 cycles with `P_DATA_PRIO=0` → grants alternate d, i, d, i, d, i, and each port receives 3 `rvalid` pulses. With `P_DATA_PRIO=1` → 6 data grants, `ow_i_ready` never high.
- Reset asserted the cycle after a data read grant → `or_d_rvalid` and `or_d_rdata` go 0 immediately, and no `rvalid` appears after deassertion.
- `iw_rst_n` low while `iw_d_valid=1` and `iw_d_we=1` → `ow_mem_we`=0 throughout, and mem contents are unchanged.
- Insn read granted, followed by 3 idle cycles → `or_i_rdata` holds the returned value, and `or_i_rvalid` is a single-cycle pulse.
